// File: rtl/codec_cfg_sequencer.sv
// Audio codec register-init sequencer: writes a 9-entry I2C table with NACK retry and inter-transfer pacing.
// Runtime headphone-volume updates are compiled in only when CODEC_VOL_UPDATE_EN is defined.
module codec_cfg_sequencer #(
   parameter logic [7:0]  DEV_ADDR   = 8'h34,
   parameter int unsigned GAP_CYCLES = 1024,
   parameter int unsigned MAX_RETRY  = 3
) (
   input  logic        CLOCK,
   input  logic        RESET,
   input  logic        START,
   input  logic        VOL_REQ,
   input  logic [6:0]  VOL_VAL,
   output logic [23:0] I2C_DATA,
   output logic        I2C_GO,
   input  logic        I2C_END,
   input  logic        I2C_ACK,
   output logic        BUSY,
   output logic        DONE,
   output logic        ERROR,
   output logic        VOL_ACK
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ISSUE = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_GAP   = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;
   localparam logic [2:0] S_ERR   = 3'd5;

   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int RW = $clog2(MAX_RETRY + 1);

   localparam logic [GW-1:0] GAP_LAST    = GW'(GAP_CYCLES - 1);
   localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);
   localparam logic [3:0]    IDX_LAST    = 4'd8;
   localparam logic [6:0]    VOL_RESET   = 7'h79;

`ifdef CODEC_VOL_UPDATE_EN
   localparam logic [3:0]    IDX_VOL_FIRST = 4'd6;
   localparam logic [3:0]    IDX_VOL_LAST  = 4'd7;
`endif

   // Entries 6 and 7 are the left/right headphone volume registers.
   function automatic logic [15:0] table_entry(input logic [3:0] idx, input logic [6:0] vol);
      logic [15:0] entry;
      case (idx)
         4'd0:    entry = 16'h0C00;
         4'd1:    entry = 16'h0EC2;
         4'd2:    entry = 16'h0838;
         4'd3:    entry = 16'h1000;
         4'd4:    entry = 16'h0017;
         4'd5:    entry = 16'h0217;
         4'd6:    entry = {8'h04, 1'b0, vol};
         4'd7:    entry = {8'h06, 1'b0, vol};
         default: entry = 16'h1201;
      endcase
      return entry;
   endfunction

   logic [2:0]    state_q,   state_d;
   logic [3:0]    idx_q,     idx_d;
   logic [RW-1:0] retry_q,   retry_d;
   logic [GW-1:0] gap_cnt_q, gap_cnt_d;
   logic [23:0]   data_q,    data_d;
   logic [RW-1:0] retry_inc;
   logic [3:0]    last_idx;
   logic [6:0]    table_vol;

`ifdef CODEC_VOL_UPDATE_EN
   logic [6:0] vol_q,        vol_d;
   logic [6:0] pend_val_q,   pend_val_d;
   logic       pend_valid_q, pend_valid_d;
   logic       vol_run_q,    vol_run_d;
   logic       vol_ack_q,    vol_ack_d;
`endif

   always_comb begin
      // NOTE: every combinational target gets a default first, so no branch can leave it unassigned and infer a latch.
      state_d   = state_q;
      idx_d     = idx_q;
      retry_d   = retry_q;
      gap_cnt_d = gap_cnt_q;
      data_d    = data_q;
      retry_inc = retry_q + 1'b1;
`ifdef CODEC_VOL_UPDATE_EN
      vol_d        = vol_q;
      pend_val_d   = pend_val_q;
      pend_valid_d = pend_valid_q;
      vol_run_d    = vol_run_q;
      vol_ack_d    = 1'b0;
      last_idx     = vol_run_q ? IDX_VOL_LAST : IDX_LAST;
      if (VOL_REQ && (state_q == S_ISSUE || state_q == S_WAIT || state_q == S_GAP)) begin
         pend_valid_d = 1'b1;
         pend_val_d   = VOL_VAL;
      end
`else
      last_idx = IDX_LAST;
`endif

      case (state_q)
         S_ISSUE: state_d = S_WAIT;

         S_WAIT: begin
            if (I2C_END) begin
               if (I2C_ACK) begin
                  retry_d = '0;
                  if (idx_q == last_idx) begin
                     state_d = S_DONE;
`ifdef CODEC_VOL_UPDATE_EN
                     vol_ack_d = vol_run_q;
`endif
                  end else begin
                     idx_d     = idx_q + 4'd1;
                     gap_cnt_d = '0;
                     state_d   = S_GAP;
                  end
               end else begin
                  retry_d = retry_inc;
                  if (retry_inc < RETRY_LIMIT) begin
                     gap_cnt_d = '0;
                     state_d   = S_GAP;
                  end else begin
                     state_d = S_ERR;
                  end
               end
            end
         end

         S_GAP: begin
            if (gap_cnt_q == GAP_LAST) state_d = S_ISSUE;
            else                       gap_cnt_d = gap_cnt_q + 1'b1;
         end

         S_IDLE, S_DONE, S_ERR: begin
            if (START) begin
               state_d = S_ISSUE;
               idx_d   = '0;
               retry_d = '0;
`ifdef CODEC_VOL_UPDATE_EN
               vol_run_d = 1'b0;
`endif
            end
`ifdef CODEC_VOL_UPDATE_EN
            // A fresh request in DONE supersedes anything still pending.
            else if (state_q == S_DONE && (VOL_REQ || pend_valid_q)) begin
               state_d      = S_ISSUE;
               idx_d        = IDX_VOL_FIRST;
               retry_d      = '0;
               vol_run_d    = 1'b1;
               pend_valid_d = 1'b0;
               vol_d        = VOL_REQ ? VOL_VAL : pend_val_q;
            end
`endif
         end

         default: state_d = S_IDLE;
      endcase

`ifdef CODEC_VOL_UPDATE_EN
      table_vol = vol_d;
`else
      table_vol = VOL_RESET;
`endif
      // The word is loaded on ISSUE entry so it is valid alongside GO and holds until the next issue.
      if (state_d == S_ISSUE && state_q != S_ISSUE) data_d = {DEV_ADDR, table_entry(idx_d, table_vol)};
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         retry_q   <= '0;
         gap_cnt_q <= '0;
         data_q    <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         retry_q   <= retry_d;
         gap_cnt_q <= gap_cnt_d;
         data_q    <= data_d;
      end
   end

`ifdef CODEC_VOL_UPDATE_EN
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         vol_q        <= VOL_RESET;
         pend_val_q   <= '0;
         pend_valid_q <= 1'b0;
         vol_run_q    <= 1'b0;
         vol_ack_q    <= 1'b0;
      end else begin
         vol_q        <= vol_d;
         pend_val_q   <= pend_val_d;
         pend_valid_q <= pend_valid_d;
         vol_run_q    <= vol_run_d;
         vol_ack_q    <= vol_ack_d;
      end
   end

   assign VOL_ACK = vol_ack_q;
`else
   logic unused_vol;
   assign unused_vol = ^{VOL_REQ, VOL_VAL};
   assign VOL_ACK    = 1'b0;
`endif

   assign I2C_DATA = data_q;
   assign I2C_GO   = (state_q == S_ISSUE);
   assign BUSY     = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_GAP);
   assign DONE     = (state_q == S_DONE);
   assign ERROR    = (state_q == S_ERR);

endmodule

// File: doc/codec_cfg_sequencer.md
CODEC_CFG_SEQUENCER -- requirements
Module: codec_cfg_sequencer

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 8'h34: codec I2C write address, placed in I2C_DATA[23:16].
REQ-002 SHALL have parameter GAP_CYCLES, default 1024: idle CLOCK cycles between consecutive transfers.
REQ-003 SHALL have parameter MAX_RETRY, default 3: NACKed attempts allowed per entry before error.
REQ-004 SHALL have port CLOCK  in  1: single clock; all logic on its rising edge.
REQ-005 SHALL have port RESET  in  1: synchronous, active-high reset.
REQ-006 SHALL have port START  in  1: one-cycle pulse that begins the full init sequence.
REQ-007 SHALL have port VOL_REQ  in  1: one-cycle pulse requesting a headphone volume update.
REQ-008 SHALL have port VOL_VAL  in  7: requested volume code, sampled when VOL_REQ=1.
REQ-009 SHALL have port I2C_DATA  out  24: {DEV_ADDR, reg[6:0], data[8:0]} word for the I2C serializer.
REQ-010 SHALL have port I2C_GO  out  1: one-cycle transfer-start strobe to the serializer.
REQ-011 SHALL have port I2C_END  in  1: one-cycle transfer-complete pulse from the serializer.
REQ-012 SHALL have port I2C_ACK  in  1: valid with I2C_END; 1 = all bytes acknowledged.
REQ-013 SHALL have ports BUSY, DONE, ERROR, VOL_ACK  out  1 each: status flags.

Function
REQ-014 Table SHALL be 9 entries, idx 0..8: 0C00, 0EC2, 0838, 1000, 0017, 0217, {8'h04,1'b0,vol}, {8'h06,1'b0,vol}, 1201.
REQ-015 vol SHALL be a 7-bit register, reset value 7'h79, overwritten from VOL_VAL on an accepted VOL_REQ.
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT, GAP, DONE, ERR.
REQ-017 IDLE/DONE/ERR + START: next edge idx=0, retry=0, DONE=0, ERROR=0, go to ISSUE; START in any other state SHALL be ignored.
REQ-018 ISSUE SHALL drive I2C_DATA={DEV_ADDR,table[idx]} and assert I2C_GO for exactly one cycle, then enter WAIT; I2C_DATA SHALL hold stable until the next ISSUE.
REQ-019 WAIT + I2C_END + I2C_ACK=1: retry=0; if idx = last entry of the active run, enter DONE, else idx+1 and enter GAP.
REQ-020 WAIT + I2C_END + I2C_ACK=0: retry+1; if new retry < MAX_RETRY enter GAP and reissue the same idx, else enter ERR.
REQ-021 GAP SHALL count exactly GAP_CYCLES cycles, then enter ISSUE.
REQ-022 I2C_END outside WAIT SHALL be ignored.
REQ-023 BUSY SHALL be 1 in ISSUE, WAIT, GAP; DONE SHALL be 1 only in DONE; ERROR SHALL be 1 only in ERR.
REQ-024 Volume run: from DONE, an accepted VOL_REQ writes idx 6 and 7 only (last entry 7); on completion assert VOL_ACK for one cycle and return to DONE.
REQ-025 VOL_REQ while BUSY SHALL latch VOL_VAL into a one-deep pending slot (newer request overwrites); the run starts on DONE entry, and vol updates only then.
REQ-026 VOL_REQ in IDLE or ERR SHALL be ignored.

Reset
REQ-027 RESET=1 at a rising edge SHALL force IDLE, idx=0, retry=0, vol=7'h79, pending cleared, I2C_DATA=0, I2C_GO=0, BUSY=DONE=ERROR=VOL_ACK=0, including mid-transfer.
REQ-028 RESET SHALL override START, VOL_REQ and I2C_END presented in the same cycle.

Configuration
REQ-029 Macro CODEC_VOL_UPDATE_EN defined: REQ-024/025 volume run and pending slot present.
REQ-030 Macro undefined: VOL_REQ/VOL_VAL ignored, VOL_ACK tied 0, vol constant 7'h79, no pending logic.

Verification
REQ-031 RESET, START, serializer ACKs every transfer after 10 cycles -> 9 GO pulses, words 340C00..341201 in order with GAP_CYCLES spacing, DONE=1.
REQ-032 NACK idx 3 twice then ACK -> 341000 issued 3 times, sequence completes, ERROR=0.
REQ-033 NACK idx 2 three times -> ERR, ERROR=1, BUSY=0, no further GO; START then restarts at 340C00.
REQ-034 In DONE, VOL_REQ with VOL_VAL=7'h60 -> words 340460, 340660, one VOL_ACK pulse, DONE=1 (macro on).
REQ-035 VOL_REQ 7'h50 then 7'h55 during init -> after 341201, volume run issues 340455, 340655 once.
REQ-036 RESET asserted in WAIT at idx 4 -> next edge all outputs 0, late I2C_END ignored, START restarts at idx 0.
